// File: rtl/mem_bus_decoder.sv
// CPU-bus slave: decodes a word address to SDRAM / boot ROM / I/O, forwards the
// region-relative request and returns read data with a one-cycle done pulse.
module mem_bus_decoder #(
    parameter logic [26:0] SDRAM_WORDS    = 27'h1000000,
    parameter logic [26:0] IO_BASE        = 27'h7000000,
    parameter logic [26:0] IO_WORDS       = 27'h0010000,
    parameter logic [26:0] ROM_BASE       = 27'h7800000,
    parameter logic [26:0] ROM_WORDS      = 27'h0000400,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] bus_addr,
    input  logic [31:0] bus_data,
    input  logic        bus_we,
    input  logic        bus_start,
    output logic [31:0] bus_q,
    output logic        bus_done,
    output logic        bus_err,
    output logic [26:0] tgt_addr,
    output logic [31:0] tgt_data,
    output logic        tgt_we,
    output logic [2:0]  tgt_start,
    input  logic [2:0]  tgt_done,
    input  logic [95:0] tgt_q
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] cnt;

    // 28-bit compares so base+words never wraps at the top of the address space
    logic [27:0] addr28;
    logic        hit_sdram, hit_rom, hit_io;
    assign addr28    = {1'b0, bus_addr};
    assign hit_sdram = addr28 < {1'b0, SDRAM_WORDS};
    assign hit_rom   = (addr28 >= {1'b0, ROM_BASE}) &&
                       (addr28 < ({1'b0, ROM_BASE} + {1'b0, ROM_WORDS}));
    assign hit_io    = (addr28 >= {1'b0, IO_BASE}) &&
                       (addr28 < ({1'b0, IO_BASE} + {1'b0, IO_WORDS}));

    logic        sel_done;
    logic [31:0] sel_q;
    assign sel_done = |(tgt_done & tgt_start);

    always_comb begin
        sel_q = 32'h0;
        case (tgt_start)
            3'b001:  sel_q = tgt_q[31:0];
            3'b010:  sel_q = tgt_q[63:32];
            3'b100:  sel_q = tgt_q[95:64];
            default: sel_q = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 16'h0;
            bus_q     <= 32'h0;
            bus_done  <= 1'b0;
            bus_err   <= 1'b0;
            tgt_addr  <= 27'h0;
            tgt_data  <= 32'h0;
            tgt_we    <= 1'b0;
            tgt_start <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    bus_done <= 1'b0;
                    cnt      <= 16'h0;
                    if (bus_start) begin
                        tgt_data <= bus_data;
                        tgt_we   <= bus_we;
                        if (hit_sdram) begin
                            tgt_addr  <= bus_addr;
                            tgt_start <= 3'b001;
                            state     <= REQ;
                        end else if (hit_rom) begin
                            tgt_addr  <= bus_addr - ROM_BASE;
                            tgt_start <= 3'b010;
                            state     <= REQ;
                        end else if (hit_io) begin
                            tgt_addr  <= bus_addr - IO_BASE;
                            tgt_start <= 3'b100;
                            state     <= REQ;
                        end else begin
                            tgt_addr <= bus_addr;
                            bus_q    <= 32'h0;
                            bus_err  <= 1'b1;
                            bus_done <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                REQ: begin
                    // done beats a timeout landing in the same cycle
                    if (sel_done) begin
                        bus_q     <= sel_q;
                        bus_err   <= 1'b0;
                        bus_done  <= 1'b1;
                        tgt_start <= 3'b000;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus_q     <= 32'h0;
                        bus_err   <= 1'b1;
                        bus_done  <= 1'b1;
                        tgt_start <= 3'b000;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'h1;
                    end
                end
                RESP: begin
                    bus_done <= 1'b0;
                    cnt      <= 16'h0;
                    state    <= IDLE;
                end
                default: begin
                    bus_done  <= 1'b0;
                    tgt_start <= 3'b000;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed table-driven bench for mem_bus_decoder plus hand sequences for
// timeout/late-done and reset in the middle of a request.
module tb_mem_bus_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_we;
    logic        bus_start;
    logic [31:0] bus_q;
    logic        bus_done;
    logic        bus_err;
    logic [26:0] tgt_addr;
    logic [31:0] tgt_data;
    logic        tgt_we;
    logic [2:0]  tgt_start;
    logic [2:0]  tgt_done;
    logic [95:0] tgt_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_decoder #(
        .SDRAM_WORDS(27'h1000000), .IO_BASE(27'h7000000), .IO_WORDS(27'h0010000),
        .ROM_BASE(27'h7800000), .ROM_WORDS(27'h0000400), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_we(bus_we), .bus_start(bus_start), .bus_q(bus_q), .bus_done(bus_done),
        .bus_err(bus_err), .tgt_addr(tgt_addr), .tgt_data(tgt_data), .tgt_we(tgt_we),
        .tgt_start(tgt_start), .tgt_done(tgt_done), .tgt_q(tgt_q)
    );

    typedef struct {
        logic [26:0] addr;
        logic [31:0] data;
        logic        we;
        int          done_at;   // REQ cycle in which the target answers; 0 = never
        logic [31:0] q;
        logic [2:0]  exp_start;
        logic [26:0] exp_taddr;
        logic [31:0] exp_q;
        logic        exp_err;
        int          exp_lat;   // cycles from the sampling edge to bus_done
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic [26:0] a, logic [31:0] d, logic w, int dn,
                                logic [31:0] q, logic [2:0] s, logic [26:0] ta,
                                logic [31:0] eq, logic e, int lat);
        vec_t v;
        v.addr = a; v.data = d; v.we = w; v.done_at = dn; v.q = q;
        v.exp_start = s; v.exp_taddr = ta; v.exp_q = eq; v.exp_err = e; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        logic [95:0] q96;
        bit got;
        q96 = {~v.q, ~v.q ^ 32'h1, ~v.q ^ 32'h2};
        case (v.exp_start)
            3'b001:  q96[31:0]  = v.q;
            3'b010:  q96[63:32] = v.q;
            3'b100:  q96[95:64] = v.q;
            default: ;
        endcase
        @(negedge clk);
        chk("done_pulse_width", 32'(bus_done), 32'h0);
        bus_addr = v.addr; bus_data = v.data; bus_we = v.we; bus_start = 1'b1;
        tgt_q = q96; tgt_done = 3'b000;
        got = 1'b0;
        for (int n = 1; n <= v.exp_lat + 4 && !got; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("tgt_start", 32'(tgt_start), 32'(v.exp_start));
                if (v.exp_start != 3'b000) begin
                    chk("tgt_addr", 32'(tgt_addr), 32'(v.exp_taddr));
                    chk("tgt_we", 32'(tgt_we), 32'(v.we));
                    if (v.we) chk("tgt_data", tgt_data, v.data);
                end
            end
            if (v.exp_start != 3'b000 && n == v.exp_lat - 1 && n > 1)
                chk("tgt_start_hold", 32'(tgt_start), 32'(v.exp_start));
            if (bus_done) begin
                got = 1'b1;
                chk("latency", 32'(n), 32'(v.exp_lat));
                chk("bus_q", bus_q, v.exp_q);
                chk("bus_err", 32'(bus_err), 32'(v.exp_err));
                chk("tgt_start_clear", 32'(tgt_start), 32'h0);
                bus_start = 1'b0;
                tgt_done  = 3'b000;
            end else if (n == v.done_at) begin
                tgt_done = v.exp_start;
            end else if (n == 1) begin
                tgt_done = ~v.exp_start;   // non-selected targets must be ignored
            end else begin
                tgt_done = 3'b000;
            end
        end
        if (!got) begin
            chk("bus_done_seen", 32'h0, 32'h1);
            bus_start = 1'b0;
            tgt_done  = 3'b000;
        end
    endtask

    task automatic reset_mid(input logic with_done);
        @(negedge clk);
        bus_addr = 27'h0000020; bus_we = 1'b0; bus_start = 1'b1; tgt_done = 3'b000;
        @(negedge clk);
        chk("rst_pre_start", 32'(tgt_start), 32'h1);
        @(negedge clk);
        if (with_done) tgt_done = 3'b001;
        reset = 1'b1;
        #1;
        chk("rst_start_drop", 32'(tgt_start), 32'h0);
        chk("rst_no_done", 32'(bus_done), 32'h0);
        bus_start = 1'b0;
        tgt_done  = 3'b000;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_no_done", 32'(bus_done), 32'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bus_addr = '0; bus_data = '0; bus_we = 1'b0; bus_start = 1'b0;
        tgt_done = 3'b000; tgt_q = '0;

        vecs[0]  = mk(27'h0000010, 32'h0,        1'b0, 3, 32'hCAFEF00D, 3'b001, 27'h10,     32'hCAFEF00D, 1'b0, 4);
        vecs[1]  = mk(27'h7800005, 32'h0,        1'b0, 1, 32'hA5A50001, 3'b010, 27'h5,      32'hA5A50001, 1'b0, 2);
        vecs[2]  = mk(27'h7000100, 32'h12345678, 1'b1, 2, 32'hDEADBEEF, 3'b100, 27'h100,    32'hDEADBEEF, 1'b0, 3);
        vecs[3]  = mk(27'h0FFFFFF, 32'h0,        1'b0, 1, 32'h0BADF00D, 3'b001, 27'hFFFFFF, 32'h0BADF00D, 1'b0, 2);
        vecs[4]  = mk(27'h1000000, 32'h0,        1'b0, 0, 32'h11111111, 3'b000, 27'h0,      32'h0,        1'b1, 1);
        vecs[5]  = mk(27'h78003FF, 32'hFEEDFACE, 1'b1, 2, 32'h22222222, 3'b010, 27'h3FF,    32'h22222222, 1'b0, 3);
        vecs[6]  = mk(27'h7800400, 32'h0,        1'b0, 0, 32'h33333333, 3'b000, 27'h0,      32'h0,        1'b1, 1);
        vecs[7]  = mk(27'h700FFFF, 32'h0,        1'b0, 1, 32'h44444444, 3'b100, 27'hFFFF,   32'h44444444, 1'b0, 2);
        vecs[8]  = mk(27'h7010000, 32'h0,        1'b0, 0, 32'h55555555, 3'b000, 27'h0,      32'h0,        1'b1, 1);
        vecs[9]  = mk(27'h0000000, 32'h0,        1'b0, 1, 32'h66666666, 3'b001, 27'h0,      32'h66666666, 1'b0, 2);
        vecs[10] = mk(27'h7000004, 32'h0,        1'b0, 0, 32'h77777777, 3'b100, 27'h4,      32'h0,        1'b1, 1025);

        repeat (3) @(negedge clk);
        chk("rst_bus_q", bus_q, 32'h0);
        chk("rst_bus_done", 32'(bus_done), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_tgt_addr", 32'(tgt_addr), 32'h0);
        chk("rst_tgt_data", tgt_data, 32'h0);
        chk("rst_tgt_we", 32'(tgt_we), 32'h0);
        chk("rst_tgt_start", 32'(tgt_start), 32'h0);
        reset = 1'b0;

        // consecutive entries are issued the cycle after the previous bus_done
        for (int i = 0; i < 11; i++) run(vecs[i]);

        // late done from the timed-out I/O target
        tgt_done = 3'b100;
        repeat (6) begin
            @(negedge clk);
            chk("late_done_ignored", {30'h0, bus_done, |tgt_start}, 32'h0);
        end
        tgt_done = 3'b000;

        // write after read, back-to-back, checks latched write attributes
        run(vecs[0]);
        run(vecs[2]);

        reset_mid(1'b0);
        run(vecs[0]);
        reset_mid(1'b1);
        run(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected finish", checks);
        $fatal(1);
    end

endmodule
